// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration.
package mem_arb_pkg;

    localparam int unsigned DEF_INDEX_WIDTH = 19;
    localparam int unsigned DEF_DATA_WIDTH  = 64;
    localparam int unsigned DEF_MASK_WIDTH  = 64;
    localparam int unsigned NUM_REQ         = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } req_id_t;

    // Highest set bit wins; the picker only ever produces one-hot vectors.
    function automatic req_id_t onehot_to_id(input logic [2:0] oh);
        if (oh[2]) begin
            return REQ_STORE;
        end
        if (oh[1]) begin
            return REQ_LOAD;
        end
        return REQ_FETCH;
    endfunction

    // Requester that sits 'off' places after 'last' in fetch->load->store order.
    function automatic logic [1:0] rr_slot(input logic [1:0] last, input int unsigned off);
        int unsigned s;
        s = (32'(last) + off) % 32'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the three requesters, the arbiter and memory.
// master = arbiter side, slave = requesters plus memory model.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MASK_WIDTH  = DEF_MASK_WIDTH
);
    logic                   redirect_flush;

    logic                   pc_index_valid;
    logic [INDEX_WIDTH-1:0] pc_index;
    logic                   pc_index_ready;
    logic                   pc_operation_done;
    logic [DATA_WIDTH-1:0]  pc_read_data;

    logic                   opload_index_valid;
    logic [INDEX_WIDTH-1:0] opload_index;
    logic                   opload_index_ready;
    logic                   opload_operation_done;
    logic [DATA_WIDTH-1:0]  opload_read_data;

    logic                   opstore_index_valid;
    logic [INDEX_WIDTH-1:0] opstore_index;
    logic [MASK_WIDTH-1:0]  opstore_write_mask;
    logic [DATA_WIDTH-1:0]  opstore_write_data;
    logic                   opstore_index_ready;
    logic                   opstore_operation_done;

    logic                   mem_chip_enable;
    logic                   mem_write_enable;
    logic [INDEX_WIDTH-1:0] mem_index;
    logic [MASK_WIDTH-1:0]  mem_write_mask;
    logic [DATA_WIDTH-1:0]  mem_write_data;
    logic                   mem_ready;
    logic                   mem_operation_done;
    logic [DATA_WIDTH-1:0]  mem_read_data;

    modport master (
        input  redirect_flush,
        input  pc_index_valid, pc_index,
        output pc_index_ready, pc_operation_done, pc_read_data,
        input  opload_index_valid, opload_index,
        output opload_index_ready, opload_operation_done, opload_read_data,
        input  opstore_index_valid, opstore_index, opstore_write_mask, opstore_write_data,
        output opstore_index_ready, opstore_operation_done,
        output mem_chip_enable, mem_write_enable, mem_index, mem_write_mask, mem_write_data,
        input  mem_ready, mem_operation_done, mem_read_data
    );

    modport slave (
        output redirect_flush,
        output pc_index_valid, pc_index,
        input  pc_index_ready, pc_operation_done, pc_read_data,
        output opload_index_valid, opload_index,
        input  opload_index_ready, opload_operation_done, opload_read_data,
        output opstore_index_valid, opstore_index, opstore_write_mask, opstore_write_data,
        input  opstore_index_ready, opstore_operation_done,
        input  mem_chip_enable, mem_write_enable, mem_index, mem_write_mask, mem_write_data,
        output mem_ready, mem_operation_done, mem_read_data
    );

endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Combinational winner selection: valid[2:0] (fetch, load, store) to one-hot grant.
// MEM_ARB_RR_EN selects round-robin after i_last_grant, otherwise store > load > fetch.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic [2:0] i_valid,
    input  req_id_t    i_last_grant,
    output logic [2:0] o_grant
);

`ifdef MEM_ARB_RR_EN
    // w_cand[k] is the requester at priority rank k (0 = highest).
    logic [1:0] w_cand [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_cand
        assign w_cand[gi] = rr_slot(i_last_grant, gi + 1);
    end

    always_comb begin
        o_grant = '0;
        for (int k = 2; k >= 0; k--) begin
            if (i_valid[w_cand[k]]) begin
                o_grant            = '0;
                o_grant[w_cand[k]] = 1'b1;
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_last_grant;

    always_comb begin
        o_grant = '0;
        if (i_valid[REQ_STORE]) begin
            o_grant[REQ_STORE] = 1'b1;
        end else if (i_valid[REQ_LOAD]) begin
            o_grant[REQ_LOAD] = 1'b1;
        end else if (i_valid[REQ_FETCH]) begin
            o_grant[REQ_FETCH] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, LSU load and LSU store; one transaction
// in flight, completions routed to the owner. Build macro MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MASK_WIDTH  = DEF_MASK_WIDTH
)
(
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.master arb_bus
);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    req_id_t                r_grant_id;
    logic                   r_kill;
    logic                   r_we;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [MASK_WIDTH-1:0]  r_mask;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_pc_done;
    logic                   r_ld_done;
    logic                   r_st_done;
    logic [DATA_WIDTH-1:0]  r_pc_rdata;
    logic [DATA_WIDTH-1:0]  r_ld_rdata;

    logic [2:0]             w_valid;
    logic [2:0]             w_picked;
    logic [2:0]             w_grant;
    logic                   w_grant_any;
    logic                   w_ce;
    logic                   w_complete;
    logic                   w_kill_set;
    logic                   w_pc_deliver;
    logic                   w_ld_deliver;
    req_id_t                w_last_grant;

    // A redirecting frontend must not win the port with a stale fetch.
    assign w_valid = {arb_bus.opstore_index_valid,
                      arb_bus.opload_index_valid,
                      arb_bus.pc_index_valid & ~arb_bus.redirect_flush};

    mem_arb_picker u_picker (
        .i_valid      (w_valid),
        .i_last_grant (w_last_grant),
        .o_grant      (w_picked)
    );

    assign w_grant     = w_picked & {3{(r_state == IDLE) && !reset}};
    assign w_grant_any = |w_grant;

`ifdef MEM_ARB_RR_EN
    req_id_t r_last_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= REQ_STORE;
        end else if (w_grant_any) begin
            r_last_grant <= onehot_to_id(w_grant);
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = REQ_STORE;
`endif

    always_comb begin
        w_state_next = r_state;
        w_ce         = 1'b0;
        w_complete   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_any) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                w_ce = 1'b1;
                if (arb_bus.mem_ready) begin
                    if (arb_bus.mem_operation_done) begin
                        w_complete   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (arb_bus.mem_operation_done) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A flush on the completion cycle itself still squashes the fetch result.
    assign w_kill_set   = (r_state != IDLE) && (r_grant_id == REQ_FETCH) && arb_bus.redirect_flush;
    assign w_pc_deliver = w_complete && (r_grant_id == REQ_FETCH) && !r_kill && !arb_bus.redirect_flush;
    assign w_ld_deliver = w_complete && (r_grant_id == REQ_LOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant_id <= REQ_FETCH;
            r_kill     <= 1'b0;
            r_we       <= 1'b0;
            r_index    <= '0;
            r_mask     <= '0;
            r_data     <= '0;
            r_pc_done  <= 1'b0;
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            r_pc_rdata <= '0;
            r_ld_rdata <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_grant_any) begin
                r_grant_id <= onehot_to_id(w_grant);
            end
            if (w_grant[REQ_STORE]) begin
                r_we    <= 1'b1;
                r_index <= arb_bus.opstore_index;
                r_mask  <= arb_bus.opstore_write_mask;
                r_data  <= arb_bus.opstore_write_data;
            end else if (w_grant[REQ_LOAD]) begin
                r_we    <= 1'b0;
                r_index <= arb_bus.opload_index;
                r_mask  <= '0;
                r_data  <= '0;
            end else if (w_grant[REQ_FETCH]) begin
                r_we    <= 1'b0;
                r_index <= arb_bus.pc_index;
                r_mask  <= '0;
                r_data  <= '0;
            end

            if (w_complete) begin
                r_kill <= 1'b0;
            end else if (w_kill_set) begin
                r_kill <= 1'b1;
            end

            r_pc_done <= w_pc_deliver;
            r_ld_done <= w_ld_deliver;
            r_st_done <= w_complete && (r_grant_id == REQ_STORE);

            if (w_pc_deliver) begin
                r_pc_rdata <= arb_bus.mem_read_data;
            end
            if (w_ld_deliver) begin
                r_ld_rdata <= arb_bus.mem_read_data;
            end
        end
    end

    assign arb_bus.pc_index_ready         = w_grant[REQ_FETCH];
    assign arb_bus.opload_index_ready     = w_grant[REQ_LOAD];
    assign arb_bus.opstore_index_ready    = w_grant[REQ_STORE];
    assign arb_bus.pc_operation_done      = r_pc_done;
    assign arb_bus.opload_operation_done  = r_ld_done;
    assign arb_bus.opstore_operation_done = r_st_done;
    assign arb_bus.pc_read_data           = r_pc_rdata;
    assign arb_bus.opload_read_data       = r_ld_rdata;

    assign arb_bus.mem_chip_enable  = w_ce;
    assign arb_bus.mem_write_enable = r_we;
    assign arb_bus.mem_index        = r_index;
    assign arb_bus.mem_write_mask   = r_mask;
    assign arb_bus.mem_write_data   = r_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and memory responder,
// expectations from a transaction-level model (MEM_ARB_RR_EN selects the RR model).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int IW = 19;
    localparam int DW = 64;
    localparam int MW = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    mem_port_arbiter #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clock   (clock),
        .reset   (reset),
        .arb_bus (bus.master)
    );

    typedef struct {
        logic          we;
        logic [IW-1:0] idx;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int unsigned   due;
    } done_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    req_t        exp_req[$];
    done_t       exp_done[$];
    logic        mon_busy   = 1'b0;
    logic        mon_acc    = 1'b0;
    logic        mon_killed = 1'b0;
    int          mon_owner  = 0;
    int          model_last = 2;
    logic        post_reset = 1'b0;
    logic [DW-1:0] pc_model = '0;
    logic [DW-1:0] ld_model = '0;
    int unsigned acc_cnt[3];
    int unsigned seen_cnt[3];

    int          rsp_min_wait  = 0;
    int          rsp_ready_pct = 100;
    int          rsp_done_pct  = 100;
    int          rsp_spur_pct  = 0;
    logic        rsp_fixed     = 1'b0;
    logic [DW-1:0] rsp_data    = '0;
    int          rsp_phase     = 0;
    int          rsp_ce_cnt    = 0;
    logic        rsp_in_reset  = 1'b1;

    function automatic bit pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Requester that should win given the currently asserted (flush-gated) valids.
    function automatic int model_pick(input logic [2:0] v);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int r;
            r = (model_last + k) % 3;
            if (v[r]) return r;
        end
        return -1;
`else
        if (v[2]) return 2;
        if (v[1]) return 1;
        if (v[0]) return 0;
        return -1;
`endif
    endfunction

    task automatic monitor_cycle();
        logic [2:0] rdy;
        logic [2:0] dn;
        logic [2:0] vld;
        logic [2:0] exp_dn;
        int         w;
        req_t       rq;
        done_t      de;
        done_t      keep[$];

        cyc++;
        rdy = {bus.opstore_index_ready, bus.opload_index_ready, bus.pc_index_ready};
        dn  = {bus.opstore_operation_done, bus.opload_operation_done, bus.pc_operation_done};
        vld = {bus.opstore_index_valid, bus.opload_index_valid,
               bus.pc_index_valid & ~bus.redirect_flush};

        for (int r = 0; r < 3; r++) begin
            if (rdy[r]) acc_cnt[r]++;
        end

        if (reset) begin
            chk("reset_ready", 64'(rdy), 64'd0);
            mon_busy = 1'b0;
            exp_req.delete();
            keep.delete();
            foreach (exp_done[i]) if (exp_done[i].due == cyc) keep.push_back(exp_done[i]);
            exp_done = keep;
        end else begin
            if (post_reset) begin
                chk("post_reset_ce", 64'(bus.mem_chip_enable), 64'd0);
                chk("post_reset_we", 64'(bus.mem_write_enable), 64'd0);
                chk("post_reset_index", 64'(bus.mem_index), 64'd0);
                chk("post_reset_mask", 64'(bus.mem_write_mask), 64'd0);
                chk("post_reset_wdata", 64'(bus.mem_write_data), 64'd0);
                post_reset = 1'b0;
            end

            if (!mon_busy) begin
                w = model_pick(vld);
                chk("grant", 64'(rdy), (w < 0) ? 64'd0 : (64'd1 << w));
                if (w >= 0) begin
                    rq.we   = (w == 2);
                    rq.idx  = (w == 2) ? bus.opstore_index : (w == 1) ? bus.opload_index : bus.pc_index;
                    rq.mask = bus.opstore_write_mask;
                    rq.data = bus.opstore_write_data;
                    exp_req.push_back(rq);
                    mon_busy   = 1'b1;
                    mon_acc    = 1'b0;
                    mon_killed = 1'b0;
                    mon_owner  = w;
                    model_last = w;
                end
            end else begin
                chk("no_ready_while_busy", 64'(rdy), 64'd0);
                if (!mon_acc) begin
                    chk("req_ce", 64'(bus.mem_chip_enable), 64'd1);
                    if (exp_req.size() > 0) begin
                        chk("req_index", 64'(bus.mem_index), 64'(exp_req[0].idx));
                        chk("req_we", 64'(bus.mem_write_enable), 64'(exp_req[0].we));
                        if (exp_req[0].we) begin
                            chk("req_mask", bus.mem_write_mask, exp_req[0].mask);
                            chk("req_wdata", bus.mem_write_data, exp_req[0].data);
                        end
                    end
                end else begin
                    chk("wait_ce_low", 64'(bus.mem_chip_enable), 64'd0);
                end
                if (bus.redirect_flush && mon_owner == 0) mon_killed = 1'b1;
                if ((!mon_acc && bus.mem_ready && bus.mem_operation_done) ||
                    (mon_acc && bus.mem_operation_done)) begin
                    if (exp_req.size() > 0) void'(exp_req.pop_front());
                    mon_busy = 1'b0;
                    if (!(mon_owner == 0 && mon_killed)) begin
                        de.owner = mon_owner;
                        de.data  = bus.mem_read_data;
                        de.due   = cyc + 1;
                        exp_done.push_back(de);
                    end
                end else if (!mon_acc && bus.mem_ready) begin
                    mon_acc = 1'b1;
                end
            end
        end

        exp_dn = 3'b000;
        if (exp_done.size() > 0 && exp_done[0].due == cyc) begin
            de = exp_done.pop_front();
            exp_dn[de.owner] = 1'b1;
            if (de.owner == 0) pc_model = de.data;
            if (de.owner == 1) ld_model = de.data;
        end
        chk("done", 64'(dn), 64'(exp_dn));
        chk("pc_read_data", bus.pc_read_data, pc_model);
        chk("opload_read_data", bus.opload_read_data, ld_model);

        if (reset) begin
            post_reset = 1'b1;
            pc_model   = '0;
            ld_model   = '0;
            model_last = 2;
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            monitor_cycle();
        end
    end

    // Memory responder: drives #2 after the edge so responder settings changed at #1 are seen.
    initial begin
        bus.mem_ready          = 1'b0;
        bus.mem_operation_done = 1'b0;
        bus.mem_read_data      = '0;
        forever begin
            @(negedge clock);
            rsp_in_reset = reset;
            if (reset) begin
                rsp_phase  = 0;
                rsp_ce_cnt = 0;
            end else if (bus.mem_chip_enable && bus.mem_ready) begin
                rsp_phase  = bus.mem_operation_done ? 0 : 1;
                rsp_ce_cnt = 0;
            end else if (rsp_phase == 1 && bus.mem_operation_done) begin
                rsp_phase = 0;
            end
            @(posedge clock);
            #2;
            bus.mem_ready          = 1'b0;
            bus.mem_operation_done = 1'b0;
            bus.mem_read_data      = rsp_fixed ? rsp_data : {$urandom, $urandom};
            if (bus.mem_chip_enable) begin
                rsp_ce_cnt++;
                if (rsp_ce_cnt > rsp_min_wait && pct(rsp_ready_pct)) begin
                    bus.mem_ready          = 1'b1;
                    bus.mem_operation_done = pct(rsp_done_pct);
                end
            end else if (rsp_phase == 1) begin
                bus.mem_operation_done = pct(rsp_done_pct);
            end else begin
                bus.mem_operation_done = pct(rsp_spur_pct);
            end
        end
    end

    task automatic service();
        for (int r = 0; r < 3; r++) begin
            if (acc_cnt[r] != seen_cnt[r]) begin
                seen_cnt[r] = acc_cnt[r];
                case (r)
                    0: bus.pc_index_valid      = 1'b0;
                    1: bus.opload_index_valid  = 1'b0;
                    default: bus.opstore_index_valid = 1'b0;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        service();
    endtask

    task automatic raise(input int r, input logic [IW-1:0] idx,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        case (r)
            0: begin bus.pc_index_valid = 1'b1; bus.pc_index = idx; end
            1: begin bus.opload_index_valid = 1'b1; bus.opload_index = idx; end
            default: begin
                bus.opstore_index_valid = 1'b1;
                bus.opstore_index       = idx;
                bus.opstore_write_mask  = m;
                bus.opstore_write_data  = d;
            end
        endcase
    endtask

    function automatic logic [2:0] valids();
        return {bus.opstore_index_valid, bus.opload_index_valid, bus.pc_index_valid};
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((valids() != 3'b000 || mon_busy || exp_done.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout cyc=%0d got=busy expected=idle within %0d cycles", name, cyc, budget);
        end
    endtask

    task automatic wait_accept(input int r, input int budget);
        int unsigned base;
        int n;
        base = seen_cnt[r];
        n = 0;
        while (seen_cnt[r] == base && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (seen_cnt[r] == base) begin
            errors++;
            $display("FAIL accept_timeout cyc=%0d requester=%0d got=no_ready expected=ready", cyc, r);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                   = 1'b1;
        bus.redirect_flush      = 1'b0;
        bus.pc_index_valid      = 1'b0;
        bus.pc_index            = '0;
        bus.opload_index_valid  = 1'b0;
        bus.opload_index        = '0;
        bus.opstore_index_valid = 1'b0;
        bus.opstore_index       = '0;
        bus.opstore_write_mask  = '0;
        bus.opstore_write_data  = '0;
        for (int r = 0; r < 3; r++) begin
            acc_cnt[r]  = 0;
            seen_cnt[r] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single load with a known read value.
        rsp_fixed = 1'b1;
        rsp_data  = 64'h0000_0000_CAFE_F00D;
        raise(1, 19'h00123, '0, '0);
        wait_idle("single_load", 50);
        chk("single_load_data", bus.opload_read_data, 64'h0000_0000_CAFE_F00D);
        rsp_fixed = 1'b0;

        // All three requesters at once.
        raise(2, 19'h00abc, 64'h0000_0000_FFFF_FFFF, 64'h1122_3344_5566_7788);
        raise(1, 19'h00456, '0, '0);
        raise(0, 19'h00789, '0, '0);
        wait_idle("all_three", 100);

        // Memory backpressure for five cycles with a competing requester.
        rsp_min_wait = 5;
        raise(1, 19'h01111, '0, '0);
        raise(0, 19'h02222, '0, '0);
        wait_idle("backpressure", 100);
        rsp_min_wait = 0;

        // Redirect while a fetch waits for memory, then a normal load.
        rsp_done_pct = 0;
        raise(0, 19'h03333, '0, '0);
        wait_accept(0, 20);
        tick();
        bus.redirect_flush = 1'b1;
        tick();
        bus.redirect_flush = 1'b0;
        rsp_done_pct = 100;
        wait_idle("flush_fetch", 50);
        raise(1, 19'h04444, '0, '0);
        wait_idle("load_after_flush", 50);

        // Randomized traffic with flushes, backpressure and stray completions.
        rsp_ready_pct = 50;
        rsp_done_pct  = 50;
        rsp_spur_pct  = 10;
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int r = 0; r < 3; r++) begin
                if (!valids()[r] && pct(30)) raise(r, IW'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            end
            bus.redirect_flush = pct(10);
        end
        bus.redirect_flush = 1'b0;
        wait_idle("random", 400);

        // Reset while a load waits for memory, then a late completion.
        rsp_ready_pct = 100;
        rsp_done_pct  = 0;
        rsp_spur_pct  = 0;
        raise(1, 19'h05555, '0, '0);
        wait_accept(1, 20);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_spur_pct = 100;
        repeat (3) tick();
        rsp_spur_pct = 0;
        rsp_done_pct = 100;
        raise(1, 19'h06666, '0, '0);
        wait_idle("after_reset", 50);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single L1 D$/memory port between three requesters: instruction fetch, the LSU load channel (opload_*) and the LSU store channel (opstore_*).
- Sits between frontend/backend and memory.
- Arbitrates, latches the winning request, sequences one outstanding transaction at a time, and routes completion and read data back to the owner.
- Squashes fetch completions after a redirect.

Parameters:
INDEX_WIDTH, 19, memory line index width
DATA_WIDTH, 64, read/write data width
MASK_WIDTH, 64, store write-mask width (bit-granular)

Ports:
- clock  in  1  — single clock.
- reset  in  1  — synchronous, active-high.
- redirect_flush  in  1  — frontend redirect; kills any outstanding fetch completion.
- Fetch requester:
  - pc_index_valid  in  1  — fetch request valid.
  - pc_index  in  INDEX_WIDTH  — fetch index.
  - pc_index_ready  out  1  — fetch request accepted.
  - pc_operation_done  out  1  — fetch complete pulse.
  - pc_read_data  out  DATA_WIDTH  — fetch data.
- Load requester:
  - opload_index_valid  in  1  — load request valid.
  - opload_index  in  INDEX_WIDTH  — load index.
  - opload_index_ready  out  1  — load accepted.
  - opload_operation_done  out  1  — load complete pulse.
  - opload_read_data  out  DATA_WIDTH  — load data.
- Store requester:
  - opstore_index_valid  in  1  — store request valid.
  - opstore_index  in  INDEX_WIDTH  — store index.
  - opstore_write_mask  in  MASK_WIDTH  — store mask.
  - opstore_write_data  in  DATA_WIDTH  — store data.
  - opstore_index_ready  out  1  — store accepted.
  - opstore_operation_done  out  1  — store complete pulse.
- Memory side:
  - mem_chip_enable  out  1  — request to memory.
  - mem_write_enable  out  1  — 1 = store.
  - mem_index  out  INDEX_WIDTH  — latched index.
  - mem_write_mask  out  MASK_WIDTH  — latched mask.
  - mem_write_data  out  DATA_WIDTH  — latched data.
  - mem_ready  in  1  — memory accepts request.
  - mem_operation_done  in  1  — memory completion.
  - mem_read_data  in  DATA_WIDTH  — memory read data.

Behaviour:
- Reset: state=IDLE; grant_id=FETCH; kill=0; all outputs 0.
- Requesters hold valid and payload until they see ready.
- FSM IDLE:
  - If any valid is high (fetch valid gated by ~redirect_flush), pick a winner. Fixed priority is store > load > fetch.
  - The winner's *_index_ready is high combinationally in that cycle (one-hot, exactly one).
  - Latch index/mask/data/write_enable and grant_id, then go to REQ.
  - No valid: stay in IDLE.
- FSM REQ:
  - mem_chip_enable=1 with latched fields, stable until mem_ready.
  - mem_ready=1: go to WAIT. If mem_operation_done is also 1 in the same cycle, complete immediately and go to IDLE.
- FSM WAIT:
  - mem_chip_enable=0.
  - mem_operation_done=1: complete and go to IDLE.
- Completion:
  - The grant_id owner's *_operation_done pulses for exactly 1 cycle, registered, in the cycle after mem_operation_done.
  - The matching *_read_data is registered from mem_read_data and held until the next completion to that owner.
  - Stores return no data.
- Minimum occupancy: IDLE→REQ→(WAIT)→IDLE is 2 cycles per transaction. A new grant is possible in the cycle completion is pulsed.
- Flush:
  - redirect_flush while grant_id=FETCH in REQ/WAIT sets kill. The memory transaction still finishes, but pc_operation_done is suppressed and pc_read_data is not updated. kill clears on return to IDLE.
  - Flush never affects load/store.
  - Flush in the same cycle as completion also suppresses pc_operation_done.
- Lost-done rule: mem_operation_done in IDLE is ignored.
- Reset mid-transaction: returns to IDLE with no done pulse. Memory-side recovery is out of scope.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. A 2-bit last_grant register makes the most recently granted requester lowest priority. Rotation order is fetch→load→store→fetch. last_grant resets to STORE, so the first-cycle order is fetch > load > store. last_grant updates only on grant.
- Undefined: fixed priority store > load > fetch, and no last_grant register exists.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_state_t {IDLE, REQ, WAIT}.
  - typedef req_id_t {REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2}.
  - Default width constants.
- Sub-module mem_arb_picker:
  - Combinational: valid[2:0] plus last_grant in, one-hot grant[2:0] out.
  - Contains both fixed and RR logic under the macro.

Test Plan:
- Single load: opload_index_valid=1 with index 0x00123.
  - Expect opload_index_ready in cycle 0, then mem_chip_enable with mem_index=0x00123, mem_write_enable=0.
  - Drive mem_ready and mem_operation_done with mem_read_data=0xCAFEF00D.
  - Expect opload_operation_done one cycle later with opload_read_data=0xCAFEF00D.
- Simultaneous all three valid (fixed priority):
  - Grant order is store, load, fetch, with exactly one ready per grant.
  - Store shows mem_write_enable=1 and the mask/data passed verbatim, e.g. mask 0x00000000FFFFFFFF, data 0x1122334455667788.
- Memory backpressure: hold mem_ready=0 for 5 cycles.
  - mem_chip_enable and mem_index stay stable.
  - No further ready to any requester.
- Flush during fetch: fetch granted; assert redirect_flush in WAIT, then mem_operation_done.
  - Expect no pc_operation_done and pc_read_data unchanged.
  - A following load is granted normally.
- Reset mid-WAIT: assert reset for 1 cycle.
  - All outputs 0, state IDLE.
  - A late mem_operation_done produces no done pulse.
- MEM_ARB_RR_EN: all three valid continuously.
  - Grants are fetch, load, store, fetch, ...
